// File: rtl/cpu_mem_arbiter.sv
// Memory arbiter between the cpu core and a host port: cpu pass-through while running,
// host byte reads/writes while the cpu is halted. Optional MEMARB_AUTOINC_EN adds an auto-incrementing host address.
module cpu_mem_arbiter #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] cpu_mem_raddr,
  input  logic [addr_width-1:0] cpu_mem_waddr,
  input  logic                  cpu_mem_write,
  input  logic [7:0]            cpu_mem_data_in,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic                  cpu_reset,
  output logic [addr_width-1:0] cpu_start_address,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [addr_width-1:0] host_addr,
  input  logic                  host_addr_ld,
  input  logic [7:0]            host_wdata,
  output logic [7:0]            host_rdata,
  output logic                  host_ack,
  input  logic                  host_run,
  input  logic [addr_width-1:0] host_run_addr,
  output logic                  host_owned,
  output logic [2:0]            dbg_state
);

  // Handshake: host_req is a level held until the one-cycle host_ack pulse;
  // host_we/host_addr/host_wdata are sampled with host_req in HOLD, and the
  // host must drop host_req the cycle after host_ack.
  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_HALTREQ = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RD0     = 3'd4;
  localparam logic [2:0] S_RD1     = 3'd5;
  localparam logic [2:0] S_RD2     = 3'd6;
  localparam logic [2:0] S_RESTART = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] haddr_q, haddr_d;
  logic [7:0]            hwdata_q, hwdata_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [addr_width-1:0] start_q, start_d;
  logic [addr_width-1:0] acc_addr;
  logic                  pass;
  logic                  owned;

`ifdef MEMARB_AUTOINC_EN
  logic [addr_width-1:0] ptr_q, ptr_d;

  assign acc_addr = host_addr_ld ? host_addr : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (host_ack) ptr_d = haddr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_addr_ld;

  assign unused_addr_ld = host_addr_ld;
  assign acc_addr       = host_addr;
`endif

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    start_d  = start_q;
    case (state_q)
      S_RUN:     if (host_req) state_d = S_HALTREQ;
      S_HALTREQ: if (cpu_halted) state_d = S_HOLD;
      S_HOLD: begin
        // An access request wins over a run request in the same cycle.
        if (host_req) begin
          haddr_d  = acc_addr;
          hwdata_d = host_wdata;
          state_d  = host_we ? S_WR : S_RD0;
        end else if (host_run) begin
          start_d = host_run_addr;
          state_d = S_RESTART;
        end
      end
      S_WR:      state_d = S_HOLD;
      S_RD0:     state_d = S_RD1;
      S_RD1:     state_d = S_RD2;
      S_RD2: begin
        rdata_d = mem_data_out;
        state_d = S_HOLD;
      end
      S_RESTART: state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      start_q  <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
    end
  end

  // HALTREQ keeps the cpu connected so a write already in flight still lands.
  assign pass  = (state_q == S_RUN) || (state_q == S_HALTREQ);
  assign owned = (state_q == S_HOLD) || (state_q == S_WR) || (state_q == S_RD0) ||
                 (state_q == S_RD1) || (state_q == S_RD2);

  assign mem_raddr   = pass ? cpu_mem_raddr   : haddr_q;
  assign mem_waddr   = pass ? cpu_mem_waddr   : haddr_q;
  assign mem_data_in = pass ? cpu_mem_data_in : hwdata_q;
  assign mem_write   = pass ? cpu_mem_write   : ((state_q == S_WR) && !reset);

  // A reset abandons the access in flight, so the pulse is suppressed.
  assign host_ack   = ((state_q == S_WR) || (state_q == S_RD2)) && !reset;
  assign host_rdata = (state_q == S_RD2) ? mem_data_out : rdata_q;
  assign host_owned = owned;

  assign cpu_halt          = owned || (state_q == S_HALTREQ);
  assign cpu_reset         = reset || (state_q == S_RESTART);
  assign cpu_start_address = start_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized scoreboard bench for cpu_mem_arbiter with a small cpu model and a byte memory.
// Build with +define+MEMARB_AUTOINC_EN to exercise the auto-increment address register.
module tb_cpu_mem_arbiter;
  localparam int AW = 9;
  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_RESTART = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_mem_raddr;
  logic [AW-1:0] cpu_mem_waddr = '0;
  logic          cpu_mem_write = 1'b0;
  logic [7:0]    cpu_mem_data_in = '0;
  logic          cpu_halt, cpu_reset;
  logic          cpu_halted;
  logic [AW-1:0] cpu_start_address;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_write;
  logic [7:0]    mem_data_in;
  logic [7:0]    mem_data_out;
  logic          host_req, host_we, host_addr_ld, host_run;
  logic [AW-1:0] host_addr, host_run_addr;
  logic [7:0]    host_wdata, host_rdata;
  logic          host_ack, host_owned;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.addr_width(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_raddr(cpu_mem_raddr), .cpu_mem_waddr(cpu_mem_waddr),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_data_in(cpu_mem_data_in),
    .cpu_halt(cpu_halt), .cpu_halted(cpu_halted), .cpu_reset(cpu_reset),
    .cpu_start_address(cpu_start_address),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_addr_ld(host_addr_ld), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .host_run(host_run), .host_run_addr(host_run_addr),
    .host_owned(host_owned), .dbg_state(dbg_state)
  );

  // cpu model: halted follows halt by two cycles, pc reloads from start address in reset.
  // Its writes stay in 0x100..0x1FE so they never touch bytes the host checks.
  logic [AW-1:0] pc = '0;
  logic          h1 = 1'b0, halted = 1'b0;
  assign cpu_mem_raddr = pc;
  assign cpu_halted    = halted;

  always @(posedge clk) begin
    if (cpu_reset) begin
      pc     <= cpu_start_address;
      h1     <= 1'b0;
      halted <= 1'b0;
    end else begin
      h1     <= cpu_halt;
      halted <= h1;
      if (!halted) pc <= pc + 1'b1;
    end
    cpu_mem_waddr   <= {1'b1, 8'($urandom_range(0, 254))};
    cpu_mem_data_in <= 8'($urandom);
    cpu_mem_write   <= !halted && !h1 && ($urandom_range(0, 2) == 0);
  end

  // Byte memory with one-cycle registered read.
  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (mem_write) mem[mem_waddr] <= mem_data_in;
    mem_data_out <= mem[mem_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]    ref_mem [512];
  logic [AW-1:0] wr_list[$];
  logic [7:0]    last_rd = '0;
  bit            rd_known = 1'b0;
  bit            owned = 1'b0;
  bit            run_phase = 1'b0;
`ifdef MEMARB_AUTOINC_EN
  logic [AW-1:0] model_ptr = '0;
`endif

  // Scoreboard queues
  logic [7:0]    exp_q[$];
  logic          exp_we_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];

  // Monitor: samples 3 time units after the falling edge, after drivers settle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (host_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got host_ack=1 expected 0 (cycle %0d)", cyc);
        end else begin
          logic [7:0] d;
          logic w;
          logic [AW-1:0] a;
          int c;
          d = exp_q.pop_front();
          w = exp_we_q.pop_front();
          a = exp_addr_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(c));
          if (w) begin
            check("wr_strobe", 32'(mem_write), 32'd1);
            check("wr_addr", 32'(mem_waddr), 32'(a));
            check("wr_data", 32'(mem_data_in), 32'(d));
          end else begin
            check("rd_data", 32'(host_rdata), 32'(d));
          end
        end
      end
      if (run_phase) begin
        check("passthru",
              32'({mem_raddr, mem_waddr, mem_write, mem_data_in, cpu_halt, host_owned}),
              32'({cpu_mem_raddr, cpu_mem_waddr, cpu_mem_write, cpu_mem_data_in, 2'b00}));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] addr,
                             input logic [7:0] wdata, input logic ld);
    logic [AW-1:0] a;
    int t0;
    bit seen;
    a = addr;
`ifdef MEMARB_AUTOINC_EN
    if (!ld) a = model_ptr;
    model_ptr = a + 1'b1;
`endif
    if (rd_known) check("rdata_hold", 32'(host_rdata), 32'(last_rd));
    @(negedge clk);
    #1;
    host_req     = 1'b1;
    host_we      = we;
    host_addr    = addr;
    host_addr_ld = ld;
    host_wdata   = wdata;
    if (!owned) begin
      run_phase = 1'b0;
      t0 = cyc;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        #1;
        if (n == 0) check("halt_rise", 32'(cpu_halt), 32'd1);
        seen = host_owned;
      end
      check("own_latency", 32'(cyc - t0), 32'd4);
      owned = 1'b1;
    end
    exp_we_q.push_back(we);
    exp_addr_q.push_back(a);
    exp_cyc_q.push_back(cyc + (we ? 1 : 3));
    exp_q.push_back(we ? wdata : ref_mem[a]);
    if (we) begin
      ref_mem[a] = wdata;
      if (a < 9'h100 || a == 9'h1FF) wr_list.push_back(a);
    end else begin
      last_rd  = ref_mem[a];
      rd_known = 1'b1;
    end
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = host_ack;
    end
    check("ack_seen", 32'(seen), 32'd1);
    host_req = 1'b0;
  endtask

  task automatic host_restart(input logic [AW-1:0] ra);
    @(negedge clk);
    #1;
    host_run      = 1'b1;
    host_run_addr = ra;
    @(negedge clk);
    #1;
    check("restart_state", 32'(dbg_state), 32'(ST_RESTART));
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_start_addr", 32'(cpu_start_address), 32'(ra));
    check("restart_halt", 32'(cpu_halt), 32'd0);
    host_run      = 1'b0;
    host_run_addr = ~ra;
    @(negedge clk);
    #1;
    check("run_state", 32'(dbg_state), 32'(ST_RUN));
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("first_fetch", 32'(mem_raddr), 32'(ra));
    check("start_addr_hold", 32'(cpu_start_address), 32'(ra));
    owned     = 1'b0;
    run_phase = 1'b1;
  endtask

  task automatic reset_in_rd1(input logic [AW-1:0] addr);
    @(negedge clk);
    #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr; host_addr_ld = 1'b1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    reset    = 1'b1;
    host_req = 1'b0;
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_no_ack", 32'(host_ack), 32'd0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));
    check("rst_owned", 32'(host_owned), 32'd0);
    check("rst_halt", 32'(cpu_halt), 32'd0);
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_start_addr", 32'(cpu_start_address), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'd0);
    reset     = 1'b0;
    owned     = 1'b0;
    run_phase = 1'b1;
    last_rd   = '0;
    rd_known  = 1'b1;
`ifdef MEMARB_AUTOINC_EN
    model_ptr = '0;
`endif
  endtask

  task automatic random_round(input int n);
    logic we;
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      we = (wr_list.size() == 0) || ($urandom_range(0, 1) == 1);
      if (we) begin
        a = 9'($urandom_range(0, 224));
        host_access(1'b1, a, 8'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        a = wr_list[$urandom_range(0, wr_list.size() - 1)];
        host_access(1'b0, a, 8'h00, 1'b1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_addr_ld = 1'b0;
    host_wdata = '0; host_run = 1'b0; host_run_addr = '0;
    @(negedge clk);
    #1;
    check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reset_halt", 32'(cpu_halt), 32'd0);
    check("reset_owned", 32'(host_owned), 32'd0);
    check("reset_ack", 32'(host_ack), 32'd0);
    check("reset_start_addr", 32'(cpu_start_address), 32'd0);
    check("reset_rdata", 32'(host_rdata), 32'd0);
    @(negedge clk);
    #1;
    reset     = 1'b0;
    run_phase = 1'b1;
    idle(20);

    host_access(1'b1, 9'h010, 8'h5A, 1'b1);
    host_access(1'b0, 9'h010, 8'h00, 1'b1);
    random_round(14);
    host_restart(9'h020);
    idle(15);

    host_access(1'b0, 9'h010, 8'h00, 1'b1);
    host_access(1'b1, 9'($urandom_range(0, 224)), 8'($urandom), 1'b1);
    reset_in_rd1(9'h010);
    idle(10);

    // Wrap of the host address at the top of memory.
    host_access(1'b1, 9'h1FE, 8'h11, 1'b1);
    host_access(1'b1, 9'h1FF, 8'h22, 1'b0);
    host_access(1'b1, 9'h000, 8'h33, 1'b0);
    host_access(1'b0, 9'h1FF, 8'h00, 1'b1);
    host_access(1'b0, 9'h000, 8'h00, 1'b1);
    random_round(8);
    host_restart(9'($urandom));
    idle(10);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
